// File: rtl/nrf_spi_master_if.sv
// Host-side command and byte-stream bundle for the nRF24L01 SPI master.
// The host owns start/tx; the master owns ready, rx and status.
interface nrf_spi_master_if #(
  parameter int NUM_CH    = 2,
  parameter int MAX_BYTES = 33
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W = $clog2(MAX_BYTES + 1);

  logic             start;
  logic [CH_W-1:0]  ch_sel;
  logic [LEN_W-1:0] num_bytes;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, ch_sel, num_bytes,
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid,
    input  busy, done
  );

  modport slave (
    input  start, ch_sel, num_bytes,
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid,
    output busy, done
  );
endinterface

// File: rtl/nrf_spi_master.sv
// Mode-0 MSB-first SPI burst master for NUM_CH nRF24L01 radios.
// Shared SCK/MOSI, per-radio CSN/CE/MISO, SCK divided from clk_in.
module nrf_spi_master #(
  parameter int NUM_CH    = 2,
  parameter int SCK_HALF  = 3,
  parameter int CSN_GAP   = 2,
  parameter int MAX_BYTES = 33
) (
  input  logic              clk_in,
  input  logic              key0_rst,
  nrf_spi_master_if.slave   bus,
  input  logic [NUM_CH-1:0] ce_req,
  output logic [NUM_CH-1:0] ce,
  output logic              sck,
  output logic              mosi,
  input  logic [NUM_CH-1:0] miso,
  output logic [NUM_CH-1:0] csn
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam int CMAX  = (2 * SCK_HALF > CSN_GAP) ?
                         2 * SCK_HALF : CSN_GAP;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, FETCH, SHIFT, HOLD, GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rxd_q, rxd_d;
  logic             rxv_q, rxv_d;
  logic             rej_q, rej_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic [NUM_CH-1:0] csn_q, csn_d;
  logic [NUM_CH-1:0] ce_q;
  logic             ch_ok;
  logic             cnt_gap;

  assign ch_ok   = int'(bus.ch_sel) < NUM_CH;
  assign cnt_gap = cnt_q == CNT_W'(CSN_GAP - 1);

  always_ff @(posedge clk_in or negedge key0_rst) begin
    if (!key0_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      ch_q    <= '0;
      tx_q    <= '0;
      sh_q    <= '0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      rej_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= '1;
      ce_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      ch_q    <= ch_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      rej_q   <= rej_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      ce_q    <= ce_req;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    ch_d    = ch_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    rej_d   = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ch_d  = bus.ch_sel;
          rem_d = (bus.num_bytes > LEN_W'(MAX_BYTES)) ?
                  LEN_W'(MAX_BYTES) : bus.num_bytes;
          if (bus.num_bytes == '0 || !ch_ok) begin
            rej_d = 1'b1;
          end else begin
            csn_d = '1;
            csn_d[bus.ch_sel] = 1'b0;
            cnt_d   = '0;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_gap) begin
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.tx_valid) begin
          tx_d    = bus.tx_data;
          mosi_d  = bus.tx_data[7];
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCK_HALF - 1)) begin
          sck_d = 1'b1;
          sh_d  = {sh_q[6:0], miso[ch_q]};
        end else if (cnt_q == CNT_W'(2 * SCK_HALF - 1)) begin
          sck_d  = 1'b0;
          cnt_d  = '0;
          bit_d  = bit_q + 1'b1;
          tx_d   = {tx_q[6:0], 1'b0};
          mosi_d = tx_q[6];
          if (bit_q == 3'd7) begin
            rxd_d  = sh_q;
            rxv_d  = 1'b1;
            rem_d  = rem_q - 1'b1;
            mosi_d = 1'b0;
            state_d = (rem_q == LEN_W'(1)) ? HOLD : FETCH;
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_gap) begin
          cnt_d   = '0;
          csn_d   = '1;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_gap) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done covers both a rejected start and the last GAP cycle
  assign bus.done     = rej_q | (state_q == GAP && cnt_gap);
  assign bus.busy     = state_q != IDLE;
  assign bus.tx_ready = state_q == FETCH;
  assign bus.rx_data  = rxd_q;
  assign bus.rx_valid = rxv_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign csn  = csn_q;
  assign ce   = ce_q;
endmodule

// File: tb/tb_nrf_spi_master.sv
// Scoreboard bench for nrf_spi_master: slave model, tx feeder, rx checker.
// A second 3-radio instance covers channel range rejection.
module tb_nrf_spi_master;
  logic       clk_in = 1'b0;
  logic       key0_rst;
  logic [1:0] ce_req, ce, miso, csn;
  logic       sck, mosi;
  logic [2:0] ce3, miso3, csn3;
  logic       sck3, mosi3;

  nrf_spi_master_if #(.NUM_CH(2), .MAX_BYTES(33)) bus();
  nrf_spi_master_if #(.NUM_CH(3), .MAX_BYTES(33)) bus3();

  nrf_spi_master #(
    .NUM_CH(2), .SCK_HALF(3), .CSN_GAP(2), .MAX_BYTES(33)
  ) dut (
    .clk_in(clk_in), .key0_rst(key0_rst), .bus(bus),
    .ce_req(ce_req), .ce(ce), .sck(sck), .mosi(mosi),
    .miso(miso), .csn(csn)
  );

  nrf_spi_master #(
    .NUM_CH(3), .SCK_HALF(3), .CSN_GAP(2), .MAX_BYTES(33)
  ) dut3 (
    .clk_in(clk_in), .key0_rst(key0_rst), .bus(bus3),
    .ce_req(3'b000), .ce(ce3), .sck(sck3), .mosi(mosi3),
    .miso(miso3), .csn(csn3)
  );

  always #10 clk_in = ~clk_in;

  int ncmp = 0;
  int nerr = 0;
  int rises = 0;
  int done_cnt = 0;
  int rx_cnt = 0;
  int tx_hs = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  // slave model on the selected radio
  int         sch = 0;
  bit         echo = 1'b0;
  logic [7:0] fixed = 8'h00;
  logic [7:0] first = 8'h00;
  logic [7:0] s_out = 8'h00;
  logic [7:0] s_in = 8'h00;
  int         nb = 0;
  logic       sel_csn;

  assign sel_csn = csn[sch];
  assign miso = (sch == 1) ? {s_out[7], 1'b1} : {1'b1, s_out[7]};

  always @(negedge sel_csn) begin
    s_out = first;
    nb = 0;
  end

  always @(posedge sck) begin
    logic [7:0] e;
    rises++;
    s_in = {s_in[6:0], mosi};
    nb++;
    if (nb == 8) begin
      ncmp++;
      if (exp_tx_q.size() == 0) begin
        nerr++;
        $display("FAIL mosi_byte: got %h, none expected", s_in);
      end else begin
        e = exp_tx_q.pop_front();
        if (s_in !== e) begin
          nerr++;
          $display("FAIL mosi_byte: got %h, want %h", s_in, e);
        end
      end
    end
  end

  always @(negedge sck) begin
    if (nb == 8) begin
      s_out = echo ? s_in : fixed;
      nb = 0;
    end else begin
      s_out = {s_out[6:0], 1'b0};
    end
  end

  always @(negedge clk_in) begin
    logic [7:0] e;
    if (bus.done) done_cnt++;
    if (key0_rst && bus.rx_valid) begin
      rx_cnt++;
      ncmp++;
      if (exp_rx_q.size() == 0) begin
        nerr++;
        $display("FAIL rx_data: got %h, none expected", bus.rx_data);
      end else begin
        e = exp_rx_q.pop_front();
        if (bus.rx_data !== e) begin
          nerr++;
          $display("FAIL rx_data: got %h, want %h", bus.rx_data, e);
        end
      end
    end
  end

  // tx feeder: presents tx_q head, retires it after a handshake
  initial begin
    bit pend;
    pend = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk_in);
      if (!key0_rst) begin
        tx_q.delete();
        pend = 1'b0;
        bus.tx_valid = 1'b0;
      end else begin
        if (pend) begin
          exp_tx_q.push_back(tx_q.pop_front());
          tx_hs++;
        end
        bus.tx_valid = tx_q.size() != 0;
        bus.tx_data  = bus.tx_valid ? tx_q[0] : 8'h00;
        pend = bus.tx_valid && bus.tx_ready;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic start_burst(input logic ch, input logic [5:0] n);
    @(negedge clk_in);
    bus.ch_sel = ch;
    bus.num_bytes = n;
    bus.start = 1'b1;
    @(negedge clk_in);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int lim);
    int k;
    k = 0;
    while (done_cnt == d0 && k < lim) begin
      @(negedge clk_in);
      k++;
    end
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_reset();
    key0_rst = 1'b0;
    ce_req = 2'b11;
    bus.start = 1'b0;
    bus.ch_sel = 1'b0;
    bus.num_bytes = '0;
    bus3.start = 1'b0;
    bus3.ch_sel = '0;
    bus3.num_bytes = '0;
    bus3.tx_valid = 1'b0;
    bus3.tx_data = 8'h00;
    miso3 = 3'b000;
    repeat (3) @(negedge clk_in);
    ncmp++;
    if (csn !== 2'b11) begin
      nerr++;
      $display("FAIL rst_csn: got %b, want 11", csn);
    end
    ncmp++;
    if ({sck, mosi, ce} !== 4'b0000) begin
      nerr++;
      $display("FAIL rst_pins: got %b, want 0000", {sck, mosi, ce});
    end
    ncmp++;
    if ({bus.tx_ready, bus.rx_valid, bus.done, bus.busy,
         bus.rx_data} !== 12'h000) begin
      nerr++;
      $display("FAIL rst_bus: got %b%b%b%b %h, want 0000 00",
               bus.tx_ready, bus.rx_valid, bus.done, bus.busy,
               bus.rx_data);
    end
    #2 key0_rst = 1'b1;
    @(negedge clk_in);
    ncmp++;
    if (ce !== 2'b11) begin
      nerr++;
      $display("FAIL rst_ce: got %b, want 11", ce);
    end
    ce_req = 2'b00;
    @(negedge clk_in);
  endtask

  task automatic test_single();
    int r0, d0, x0, cyc, cf, fr, lr, bad_int, bad_csn, nr;
    logic sp;
    sch = 1; echo = 1'b0; fixed = 8'h0E; first = 8'h0E;
    exp_rx_q.push_back(8'h0E);
    tx_q.push_back(8'hA5);
    r0 = rises; d0 = done_cnt; x0 = rx_cnt;
    cf = -1; fr = -1; lr = 0; bad_int = 0; bad_csn = 0;
    nr = 0; sp = 1'b0; cyc = 0;
    start_burst(1'b1, 6'd1);
    while (done_cnt == d0 && cyc < 300) begin
      if (csn != 2'b11 && csn != 2'b01) bad_csn++;
      if (csn == 2'b01 && cf < 0) cf = cyc;
      if (sck && !sp) begin
        if (fr < 0) fr = cyc;
        else if (cyc - lr != 6) bad_int++;
        lr = cyc;
        nr++;
      end
      sp = sck;
      @(negedge clk_in);
      cyc++;
    end
    repeat (2) @(negedge clk_in);
    ncmp++;
    if (nr != 8 || rises - r0 != 8) begin
      nerr++;
      $display("FAIL single_sck: got %0d rises, want 8", nr);
    end
    ncmp++;
    if (bad_int != 0) begin
      nerr++;
      $display("FAIL single_period: got %0d bad periods, want 0",
               bad_int);
    end
    ncmp++;
    if (bad_csn != 0 || cf != 0) begin
      nerr++;
      $display("FAIL single_csn: got %0d bad, fall %0d, want 0/0",
               bad_csn, cf);
    end
    ncmp++;
    if (fr - cf < 5) begin
      nerr++;
      $display("FAIL single_setup: got %0d cycles, want >=5",
               fr - cf);
    end
    ncmp++;
    if (rx_cnt - x0 != 1 || done_cnt - d0 != 1 || bus.busy !== 1'b0)
    begin
      nerr++;
      $display("FAIL single_end: got rx %0d done %0d busy %b, want 1 1 0",
               rx_cnt - x0, done_cnt - d0, bus.busy);
    end
  endtask

  task automatic test_burst(input logic [5:0] n);
    int r0, d0, x0, h0;
    sch = 0; echo = 1'b1; first = 8'hFF;
    exp_rx_q.push_back(8'hFF);
    for (int i = 0; i < 33; i++) begin
      tx_q.push_back(8'(i));
      if (i < 32) exp_rx_q.push_back(8'(i));
    end
    r0 = rises; d0 = done_cnt; x0 = rx_cnt; h0 = tx_hs;
    start_burst(1'b0, n);
    wait_done(d0, 3000);
    ncmp++;
    if (rises - r0 != 264 || tx_hs - h0 != 33) begin
      nerr++;
      $display("FAIL burst%0d_len: got %0d rises %0d hs, want 264 33",
               n, rises - r0, tx_hs - h0);
    end
    ncmp++;
    if (rx_cnt - x0 != 33 || done_cnt - d0 != 1) begin
      nerr++;
      $display("FAIL burst%0d_rx: got %0d rx %0d done, want 33 1",
               n, rx_cnt - x0, done_cnt - d0);
    end
  endtask

  task automatic test_stall();
    int r0, d0, x0, k, bad;
    sch = 0; echo = 1'b0; fixed = 8'h3C; first = 8'h3C;
    repeat (3) exp_rx_q.push_back(8'h3C);
    tx_q.push_back(8'h11);
    r0 = rises; d0 = done_cnt; x0 = rx_cnt;
    start_burst(1'b0, 6'd3);
    k = 0;
    while (rx_cnt == x0 && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (sck !== 1'b0 || csn !== 2'b10 || bus.tx_ready !== 1'b1)
        bad++;
    end
    ncmp++;
    if (bad != 0 || k >= 200) begin
      nerr++;
      $display("FAIL stall_hold: got %0d bad cycles, want 0", bad);
    end
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    wait_done(d0, 500);
    ncmp++;
    if (rx_cnt - x0 != 3 || rises - r0 != 24 || done_cnt - d0 != 1)
    begin
      nerr++;
      $display("FAIL stall_end: got rx %0d sck %0d done %0d, want 3 24 1",
               rx_cnt - x0, rises - r0, done_cnt - d0);
    end
  endtask

  task automatic test_reject();
    int r0, d0;
    r0 = rises; d0 = done_cnt;
    start_burst(1'b0, 6'd0);
    ncmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || csn !== 2'b11) begin
      nerr++;
      $display("FAIL reject_done: got done %b busy %b csn %b, want 1 0 11",
               bus.done, bus.busy, csn);
    end
    @(negedge clk_in);
    ncmp++;
    if (bus.done !== 1'b0 || rises != r0 || done_cnt - d0 != 1) begin
      nerr++;
      $display("FAIL reject_after: got done %b sck %0d, want 0 0",
               bus.done, rises - r0);
    end
  endtask

  task automatic test_ignore_start();
    int r0, d0, k, bad;
    sch = 0; echo = 1'b0; fixed = 8'h5A; first = 8'h5A;
    exp_rx_q.push_back(8'h5A);
    exp_rx_q.push_back(8'h5A);
    tx_q.push_back(8'hC3);
    tx_q.push_back(8'h96);
    r0 = rises; d0 = done_cnt;
    start_burst(1'b0, 6'd2);
    k = 0;
    while (rises - r0 < 3 && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    bus.ch_sel = 1'b1;
    bus.num_bytes = 6'd1;
    bus.start = 1'b1;
    @(negedge clk_in);
    bus.start = 1'b0;
    bad = 0;
    k = 0;
    while (k < 200) begin
      if (csn[1] !== 1'b1) bad++;
      @(negedge clk_in);
      k++;
    end
    ncmp++;
    if (done_cnt - d0 != 1 || bad != 0 || rises - r0 != 16) begin
      nerr++;
      $display("FAIL ignore_start: got done %0d csn1low %0d sck %0d, want 1 0 16",
               done_cnt - d0, bad, rises - r0);
    end
  endtask

  task automatic test_ce();
    int r0, d0;
    logic [1:0] seq [3];
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11;
    sch = 1; echo = 1'b0; fixed = 8'h81; first = 8'h81;
    exp_rx_q.push_back(8'h81);
    tx_q.push_back(8'h7E);
    r0 = rises; d0 = done_cnt;
    start_burst(1'b1, 6'd1);
    for (int i = 0; i < 3; i++) begin
      ce_req = seq[i];
      @(negedge clk_in);
      ncmp++;
      if (ce !== seq[i]) begin
        nerr++;
        $display("FAIL ce_follow: got %b, want %b", ce, seq[i]);
      end
    end
    wait_done(d0, 300);
    ncmp++;
    if (rises - r0 != 8 || done_cnt - d0 != 1) begin
      nerr++;
      $display("FAIL ce_burst: got sck %0d done %0d, want 8 1",
               rises - r0, done_cnt - d0);
    end
    ce_req = 2'b00;
  endtask

  task automatic test_ch3();
    int k, bad, seen;
    miso3 = 3'b100;
    bus3.tx_data = 8'h55;
    bus3.tx_valid = 1'b1;
    @(negedge clk_in);
    bus3.ch_sel = 2'd2;
    bus3.num_bytes = 6'd1;
    bus3.start = 1'b1;
    @(negedge clk_in);
    bus3.start = 1'b0;
    bad = 0; seen = 0; k = 0;
    while (!bus3.done && k < 300) begin
      if (csn3 == 3'b011) seen++;
      else if (csn3 != 3'b111) bad++;
      @(negedge clk_in);
      k++;
    end
    bus3.tx_valid = 1'b0;
    @(negedge clk_in);
    ncmp++;
    if (seen == 0 || bad != 0 || bus3.rx_data !== 8'hFF) begin
      nerr++;
      $display("FAIL ch3_run: got seen %0d bad %0d rx %h, want >0 0 ff",
               seen, bad, bus3.rx_data);
    end
    bus3.ch_sel = 2'd3;
    bus3.start = 1'b1;
    @(negedge clk_in);
    bus3.start = 1'b0;
    ncmp++;
    if (bus3.done !== 1'b1 || bus3.busy !== 1'b0 || csn3 !== 3'b111)
    begin
      nerr++;
      $display("FAIL ch3_reject: got done %b busy %b csn %b, want 1 0 111",
               bus3.done, bus3.busy, csn3);
    end
  endtask

  task automatic test_reset_mid();
    int d0, x0, k;
    sch = 0; echo = 1'b0; fixed = 8'h77; first = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tx_q.push_back(8'(8'h40 + i));
      exp_rx_q.push_back(8'h77);
    end
    x0 = rx_cnt;
    start_burst(1'b0, 6'd5);
    k = 0;
    while (rx_cnt == x0 && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    while (!sck && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    #3 key0_rst = 1'b0;
    #1;
    ncmp++;
    if (csn !== 2'b11 || sck !== 1'b0 || k >= 300) begin
      nerr++;
      $display("FAIL reset_mid: got csn %b sck %b, want 11 0", csn, sck);
    end
    @(negedge clk_in);
    #2 key0_rst = 1'b1;
    exp_rx_q.delete();
    exp_tx_q.delete();
    d0 = done_cnt;
    repeat (20) @(negedge clk_in);
    ncmp++;
    if (bus.busy !== 1'b0 || bus.tx_ready !== 1'b0 || done_cnt != d0)
    begin
      nerr++;
      $display("FAIL reset_idle: got busy %b rdy %b done %0d, want 0 0 0",
               bus.busy, bus.tx_ready, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst(6'd33);
    test_burst(6'd40);
    test_stall();
    test_reject();
    test_ignore_start();
    test_ce();
    test_ch3();
    ncmp++;
    if (exp_rx_q.size() != 0 || exp_tx_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got rx %0d tx %0d left, want 0 0",
               exp_rx_q.size(), exp_tx_q.size());
    end
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/nrf_spi_master.md
Name: nrf_spi_master

Overview:
- Parametrised successor to the fixed single-byte nRF24L01 SPI controller path.
- One SPI mode-0 master, MSB first, driving NUM_CH nRF24L01 radios over a shared SCK/MOSI with per-radio CSN, CE and MISO.
- Performs variable-length bursts (command byte plus up to 32 payload bytes) with a valid/ready byte stream in and a byte strobe out.
- Generates SCK internally from clk_in, so no separate divider module is needed.

Parameters:
- NUM_CH, 2, number of radios; CH_W = max(1, $clog2(NUM_CH)).
- SCK_HALF, 3, clk_in cycles per SCK half-period (50 MHz gives 8.33 MHz SCK); must be at least 2.
- CSN_GAP, 2, cycles for each of: CSN setup before the first SCK rise, CSN hold after the last SCK fall, and minimum CSN-high time between bursts.
- MAX_BYTES, 33, largest burst; LEN_W = $clog2(MAX_BYTES+1).

Ports:
- clk_in  in  1  system clock, 50 MHz.
- key0_rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle burst request; sampled only in IDLE.
- ch_sel  in  CH_W  radio index; latched on an accepted start.
- num_bytes  in  LEN_W  burst length; latched on an accepted start.
- ce_req  in  NUM_CH  requested CE level per radio.
- tx_data  in  8  next byte to shift out.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  master accepts tx_data this cycle.
- rx_data  out  8  last byte received.
- rx_valid  out  1  one-cycle strobe; rx_data is new.
- busy  out  1  burst in progress.
- done  out  1  one-cycle strobe at end of burst.
- sck  out  1  shared SPI clock; idles low.
- mosi  out  1  shared SPI data out.
- miso  in  NUM_CH  per-radio SPI data in.
- csn  out  NUM_CH  per-radio chip select, active low.
- ce  out  NUM_CH  registered copy of ce_req.

Behaviour:
- Reset (async, key0_rst=0):
  - csn all ones; sck, mosi, ce, tx_ready, rx_valid, done, busy all 0; rx_data 0; state IDLE.
  - Reset mid-burst releases CSN immediately, without waiting for a clock edge.
- ce is registered from ce_req every cycle with 1-cycle latency, independent of the FSM.
- States: IDLE -> SETUP -> FETCH -> SHIFT -> (FETCH | HOLD) -> GAP -> IDLE.
- IDLE:
  - On start=1, latch ch_sel and n = min(num_bytes, MAX_BYTES).
  - If n=0 or ch_sel>=NUM_CH, the start is rejected: done pulses next cycle, CSN is never asserted, busy stays 0.
  - Otherwise, next cycle: busy=1, csn[ch]=0, go to SETUP.
- SETUP: hold for CSN_GAP cycles with sck=0, then go to FETCH.
- FETCH:
  - tx_ready=1. A transfer occurs when tx_valid and tx_ready are both 1.
  - On transfer: load the shift register and drive mosi=tx_data[7] on the next cycle, then go to SHIFT.
  - If tx_valid=0, stall indefinitely with CSN low and sck low.
- SHIFT, per bit:
  - sck low for SCK_HALF cycles, then high for SCK_HALF cycles.
  - On each rise, sample miso[ch].
  - On each fall, present the next bit on mosi.
  - After the 8th fall: rx_data = assembled byte (first sampled bit is MSB) and rx_valid pulses 1 cycle; decrement the remaining count; go to FETCH if bytes remain, else HOLD.
- HOLD: CSN_GAP cycles, then csn[ch]=1 and go to GAP.
- GAP:
  - CSN_GAP cycles with all CSN high.
  - On the last GAP cycle, done=1. busy falls to 0 on the cycle after done.
  - Return to IDLE.
- start asserted while busy=1 is ignored, not queued.
- tx_ready is 0 outside FETCH; tx_valid outside FETCH has no effect.
- Only csn[ch] may go low, and at most one csn bit is ever low.
- mosi is 0 whenever CSN is all high.
- The MISO of unselected radios is ignored.
- SCK has exactly 8*n rising edges per burst. No glitches: sck, mosi and csn are all registered outputs.

Test Plan:
- Reset during SHIFT of byte 2 of a 5-byte burst -> csn=2'b11 and sck=0 asynchronously; after release, IDLE with busy=0 and no done pulse.
- ch_sel=1, num_bytes=1, tx_data=8'hA5 with tx_valid held 1, miso[1] driven by a slave model returning 8'h0E, miso[0]=1:
  - csn=2'b01 throughout; mosi bits 1,0,1,0,0,1,0,1 on rising edges.
  - 8 SCK pulses with a 6-cycle period.
  - rx_data=8'h0E with one rx_valid pulse; one done pulse; busy ends 0.
  - First SCK rise at least CSN_GAP+SCK_HALF cycles after CSN falls.
- num_bytes=33, bytes 0x00..0x20, slave echoes the previous byte -> 264 SCK rises, 33 tx handshakes and 33 rx_valid pulses, rx sequence xx,00..1F; num_bytes=40 also yields exactly 33 bytes.
- tx_valid withheld 20 cycles before byte 2 of a 3-byte burst -> sck stays low, CSN stays low, tx_ready=1 for all 20 cycles, then the burst completes correctly.
- Rejected starts:
  - num_bytes=0 -> done one cycle later, csn never low, no SCK edges.
  - ch_sel=2 with NUM_CH=3, then ch_sel=3 -> the first runs on csn[2]; the second is rejected like num_bytes=0.
  - start pulsed mid-burst -> ignored; exactly one done pulse.
- ce_req toggles 2'b00->2'b10->2'b11 during a burst -> ce follows with 1-cycle latency; FSM timing unaffected.
